rggen_bit_field_counter: RTL and testbench

- Parametrised hardware-counter bit field. It replaces the fixed read-as-zero bit field as the general "hardware-owned" field type.
- The field keeps a WIDTH-bit register that hardware increments and decrements. Software reads it, loads it with masked writes, and can optionally clear it on read.
- Sits in a register block at the same bit-field interface as every other field type. Adds a sticky overflow/underflow flag.

---
 rtl/rggen_bit_field_counter.sv | 89 ++++++++
 tb/tb_rggen_bit_field_counter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_bit_field_counter.sv
// Hardware-owned counter bit field: hardware counts up/down, software reads/loads it,
// with optional saturation, clear-on-read and a sticky overflow/underflow flag.
module rggen_bit_field_counter #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
    parameter int               STEP_WIDTH    = 1,
    parameter int               SATURATE      = 0,
    parameter int               CLEAR_ON_READ = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_bit_field_valid,
    input  logic [WIDTH-1:0]      i_bit_field_read_mask,
    input  logic [WIDTH-1:0]      i_bit_field_write_mask,
    input  logic [WIDTH-1:0]      i_bit_field_write_data,
    output logic [WIDTH-1:0]      o_bit_field_read_data,
    output logic [WIDTH-1:0]      o_bit_field_value,
    input  logic                  i_clear,
    input  logic                  i_up_valid,
    input  logic [STEP_WIDTH-1:0] i_up_value,
    input  logic                  i_down_valid,
    input  logic [STEP_WIDTH-1:0] i_down_value,
    output logic                  o_overflow
);
    localparam int SUM_WIDTH = WIDTH + 2;

    logic [WIDTH-1:0]            counter;
    logic                        overflow;
    logic                        read_access;
    logic                        write_access;
    logic [STEP_WIDTH-1:0]       up_step;
    logic [STEP_WIDTH-1:0]       down_step;
    logic signed [SUM_WIDTH-1:0] sum;
    logic                        cross_high;
    logic                        cross_low;
    logic [WIDTH-1:0]            count_next;

    assign read_access  = i_bit_field_valid & (|i_bit_field_read_mask);
    assign write_access = i_bit_field_valid & (|i_bit_field_write_mask);

    assign up_step   = i_up_valid   ? i_up_value   : '0;
    assign down_step = i_down_valid ? i_down_value : '0;

    // Two guard bits hold the full range: sign in the MSB, carry-out just below it.
    assign sum = $signed({2'b00, counter})
               + $signed({{(SUM_WIDTH-STEP_WIDTH){1'b0}}, up_step})
               - $signed({{(SUM_WIDTH-STEP_WIDTH){1'b0}}, down_step});

    assign cross_low  = sum[SUM_WIDTH-1];
    assign cross_high = ~sum[SUM_WIDTH-1] & sum[WIDTH];

    always_comb begin
        count_next = sum[WIDTH-1:0];
        if (SATURATE != 0) begin
            if (cross_high) begin
                count_next = '1;
            end else if (cross_low) begin
                count_next = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            counter  <= INITIAL_VALUE;
            overflow <= 1'b0;
        end else if (i_clear) begin
            counter  <= INITIAL_VALUE;
            overflow <= 1'b0;
        end else if (write_access) begin
            counter  <= (counter & ~i_bit_field_write_mask)
                      | (i_bit_field_write_data & i_bit_field_write_mask);
            overflow <= 1'b0;
        end else if (read_access && (CLEAR_ON_READ != 0)) begin
            // Flag deliberately survives a clear-on-read.
            counter  <= INITIAL_VALUE;
        end else begin
            counter <= count_next;
            if (cross_high || cross_low) begin
                overflow <= 1'b1;
            end
        end
    end

    assign o_bit_field_read_data = counter;
    assign o_bit_field_value     = counter;
    assign o_overflow            = overflow;

endmodule

// File: tb/tb_rggen_bit_field_counter.sv
// Bench for rggen_bit_field_counter: three variants (wrap, saturate, clear-on-read) share
// one stimulus and are each checked against an integer-arithmetic reference model.
module tb_rggen_bit_field_counter;
    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] rmask;
    logic [7:0] wmask;
    logic [7:0] wdata;
    logic       clear;
    logic       up_valid;
    logic [3:0] up_value;
    logic       down_valid;
    logic [3:0] down_value;

    logic [7:0] dut_rd[3];
    logic [7:0] dut_val[3];
    logic       dut_ovf[3];

    logic [7:0] m_cnt[3];
    logic       m_ovf[3];

    int checks;
    int errors;

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: wrap, 1: saturate, 2: clear-on-read (wrap)
    rggen_bit_field_counter #(
        .WIDTH(8), .INITIAL_VALUE(8'h10), .STEP_WIDTH(4), .SATURATE(0), .CLEAR_ON_READ(0)
    ) dut_wrap (
        .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(dut_rd[0]),
        .o_bit_field_value(dut_val[0]), .i_clear(clear),
        .i_up_valid(up_valid), .i_up_value(up_value),
        .i_down_valid(down_valid), .i_down_value(down_value),
        .o_overflow(dut_ovf[0])
    );

    rggen_bit_field_counter #(
        .WIDTH(8), .INITIAL_VALUE(8'h10), .STEP_WIDTH(4), .SATURATE(1), .CLEAR_ON_READ(0)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(dut_rd[1]),
        .o_bit_field_value(dut_val[1]), .i_clear(clear),
        .i_up_valid(up_valid), .i_up_value(up_value),
        .i_down_valid(down_valid), .i_down_value(down_value),
        .o_overflow(dut_ovf[1])
    );

    rggen_bit_field_counter #(
        .WIDTH(8), .INITIAL_VALUE(8'h20), .STEP_WIDTH(4), .SATURATE(0), .CLEAR_ON_READ(1)
    ) dut_cor (
        .i_clk(clk), .i_rst(rst), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(dut_rd[2]),
        .o_bit_field_value(dut_val[2]), .i_clear(clear),
        .i_up_valid(up_valid), .i_up_value(up_value),
        .i_down_valid(down_valid), .i_down_value(down_value),
        .o_overflow(dut_ovf[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] init_of(input int k);
        return (k == 2) ? 8'h20 : 8'h10;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int s;
            if (rst || clear) begin
                m_cnt[k] = init_of(k);
                m_ovf[k] = 1'b0;
            end else if (valid && wmask != 8'h00) begin
                m_cnt[k] = (m_cnt[k] & ~wmask) | (wdata & wmask);
                m_ovf[k] = 1'b0;
            end else if (valid && rmask != 8'h00 && k == 2) begin
                m_cnt[k] = init_of(k);
            end else begin
                s = int'(m_cnt[k]) + (up_valid ? int'(up_value) : 0)
                  - (down_valid ? int'(down_value) : 0);
                if (s > 255) begin
                    m_ovf[k] = 1'b1;
                    m_cnt[k] = (k == 1) ? 8'hFF : 8'(s - 256);
                end else if (s < 0) begin
                    m_ovf[k] = 1'b1;
                    m_cnt[k] = (k == 1) ? 8'h00 : 8'(s + 256);
                end else begin
                    m_cnt[k] = 8'(s);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rst = 1'b0; clear = 1'b0; valid = 1'b0;
        rmask = 8'h00; wmask = 8'h00; wdata = 8'h00;
        up_valid = 1'b0; up_value = 4'd0; down_valid = 1'b0; down_value = 4'd0;
    endtask

    // Advance one edge; model reads the same inputs the DUTs sample.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_all(input logic [7:0] v);
        idle_inputs();
        valid = 1'b1; wmask = 8'hFF; wdata = v;
        tick();
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_val[k] !== init_of(k) || dut_ovf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: value=%h ovf=%b expected value=%h ovf=0",
                         k, dut_val[k], dut_ovf[k], init_of(k));
            end
        end
        up_valid = 1'b1; up_value = 4'd1;
        repeat (3) tick();
        idle_inputs();
        checks++;
        if (dut_val[0] !== 8'h13) begin
            errors++;
            $display("FAIL count_up3: value=%h expected=13", dut_val[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_val[k] !== m_cnt[k]) begin
                errors++;
                $display("FAIL count_up3_model[%0d]: value=%h expected=%h", k, dut_val[k], m_cnt[k]);
            end
        end
    endtask

    task automatic test_wrap_overflow();
        load_all(8'hFE);
        up_valid = 1'b1; up_value = 4'd3;
        tick();
        idle_inputs();
        checks++;
        if (dut_val[0] !== 8'h01 || dut_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_over: value=%h ovf=%b expected value=01 ovf=1", dut_val[0], dut_ovf[0]);
        end
        checks++;
        if (dut_val[1] !== 8'hFF || dut_ovf[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_over: value=%h ovf=%b expected value=ff ovf=1", dut_val[1], dut_ovf[1]);
        end
        valid = 1'b1; wmask = 8'h0F; wdata = 8'hA5;
        tick();
        idle_inputs();
        checks++;
        if (dut_val[0] !== 8'h05 || dut_ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL masked_write: value=%h ovf=%b expected value=05 ovf=0", dut_val[0], dut_ovf[0]);
        end
    endtask

    task automatic test_saturate_under();
        load_all(8'h02);
        down_valid = 1'b1; down_value = 4'd5;
        tick();
        checks++;
        if (dut_val[1] !== 8'h00 || dut_ovf[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_under: value=%h ovf=%b expected value=00 ovf=1", dut_val[1], dut_ovf[1]);
        end
        checks++;
        if (dut_val[0] !== 8'hFD || dut_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_under: value=%h ovf=%b expected value=fd ovf=1", dut_val[0], dut_ovf[0]);
        end
        up_valid = 1'b1; up_value = 4'd4; down_value = 4'd4;
        tick();
        idle_inputs();
        checks++;
        if (dut_val[1] !== 8'h00 || dut_ovf[1] !== 1'b1) begin
            errors++;
            $display("FAIL net_zero: value=%h ovf=%b expected value=00 ovf=1", dut_val[1], dut_ovf[1]);
        end
    endtask

    task automatic test_clear_on_read();
        load_all(8'h37);
        valid = 1'b1; rmask = 8'hFF; up_valid = 1'b1; up_value = 4'd1;
        #1;
        checks++;
        if (dut_rd[2] !== 8'h37) begin
            errors++;
            $display("FAIL cor_read_data: read=%h expected=37", dut_rd[2]);
        end
        tick();
        idle_inputs();
        checks++;
        if (dut_val[2] !== 8'h20) begin
            errors++;
            $display("FAIL cor_cleared: value=%h expected=20", dut_val[2]);
        end
        checks++;
        if (dut_val[0] !== 8'h38) begin
            errors++;
            $display("FAIL read_no_cor: value=%h expected=38", dut_val[0]);
        end
    endtask

    task automatic test_clear_vs_write();
        load_all(8'h80);
        clear = 1'b1; valid = 1'b1; wmask = 8'hFF; wdata = 8'h55;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_val[k] !== init_of(k)) begin
                errors++;
                $display("FAIL clear_over_write[%0d]: value=%h expected=%h", k, dut_val[k], init_of(k));
            end
        end
        valid = 1'b1; wmask = 8'hFF; wdata = 8'h55; up_valid = 1'b1; up_value = 4'd7;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_val[k] !== 8'h55) begin
                errors++;
                $display("FAIL write_over_count[%0d]: value=%h expected=55", k, dut_val[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_all(8'hFF);
        up_valid = 1'b1; up_value = 4'd1;
        tick();
        checks++;
        if (dut_val[1] !== 8'hFF || dut_ovf[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_at_ff: value=%h ovf=%b expected value=ff ovf=1", dut_val[1], dut_ovf[1]);
        end
        rst = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dut_val[k] !== init_of(k) || dut_ovf[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid[%0d]: value=%h ovf=%b expected value=%h ovf=0",
                         k, dut_val[k], dut_ovf[k], init_of(k));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            clear      = ($urandom_range(0, 39) == 0);
            valid      = ($urandom_range(0, 4) == 0);
            rmask      = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            wmask      = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            wdata      = 8'($urandom);
            up_valid   = ($urandom_range(0, 1) == 1);
            up_value   = 4'($urandom_range(0, 15));
            down_valid = ($urandom_range(0, 1) == 1);
            down_value = 4'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_rd[k] !== m_cnt[k]) begin
                    errors++;
                    $display("FAIL rand_read[%0d] cycle %0d: read=%h expected=%h", k, n, dut_rd[k], m_cnt[k]);
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dut_val[k] !== m_cnt[k] || dut_ovf[k] !== m_ovf[k]) begin
                    errors++;
                    $display("FAIL rand_state[%0d] cycle %0d: value=%h ovf=%b expected value=%h ovf=%b",
                             k, n, dut_val[k], dut_ovf[k], m_cnt[k], m_ovf[k]);
                end
            end
        end
        idle_inputs();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 8'h00;
            m_ovf[k] = 1'b0;
        end
        idle_inputs();
        test_reset();
        test_wrap_overflow();
        test_saturate_under();
        test_clear_on_read();
        test_clear_vs_write();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
